// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory read port and instruction valid/ready handshake of the fetch stage.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rden;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  modport master (output mem_addr, mem_rden, inst_valid, inst, inst_pc, input mem_q, inst_ready);
  modport slave (input mem_addr, mem_rden, inst_valid, inst, inst_pc, output mem_q, inst_ready);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing 1-cycle-latency memory reads into a tagged FIFO with redirect/halt.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  instruction_fetch_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] word_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic pop, push, issue;
  logic [CW:0] occ;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // an issue reserves a slot, so occupancy counts the in-flight word and credits this edge's pop
  always_comb begin
    pop = bus.inst_valid && bus.inst_ready && !redirect;
    push = inflight && !redirect;
    occ = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    issue = reset_n && !halt && !redirect && occ < (CW+1)'(DEPTH);
  end
  assign bus.mem_rden = issue;
  assign bus.mem_addr = fetch_pc;
  assign bus.inst_valid = count != '0;
  assign bus.inst = word_q[head];
  assign bus.inst_pc = pc_q[head];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
      inflight <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      head <= '0;
      tail <= '0;
      count <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 1'b1;
      end
      if (push) begin
        word_q[tail] <= bus.mem_q;
        pc_q[tail] <= inflight_pc;
        tail <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock)
    if (reset_n) assert (!(push && !pop && count == CW'(DEPTH)));
endmodule
